// File: rtl/imaging_mode_pulse_tx.sv
// Imaging-mode-select pulse transmitter.
// A legal request holds wms low for a guard time, so the receiver restarts its
// count, then sends (mode+1) high/low pulses and a final low tail. A request
// for a mode above MAX_MODE is rejected with a one-cycle err pulse and no
// activity on wms. Every output comes straight from a flop. The flop values
// are computed from the next state, so wms is glitch-free and an illegal state
// code drives the line low.
module imaging_mode_pulse_tx #(
  parameter logic [25:0] GUARD_CYCLES = 26'd55_000_000,
  parameter logic [15:0] HIGH_CYCLES  = 16'd500,
  parameter logic [15:0] LOW_CYCLES   = 16'd500,
  parameter logic [3:0]  MAX_MODE     = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mode_req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       wms,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One-hot codes: a single flipped bit gives an illegal code, and the
  // default branch of the next-state logic catches it.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GUARD = 5'b00010,
    HIGH  = 5'b00100,
    LOW   = 5'b01000,
    TAIL  = 5'b10000
  } state_t;

  // Terminal counts, widened to the 26-bit cycle counter.
  localparam logic [25:0] GUARD_LAST = GUARD_CYCLES - 26'd1;
  localparam logic [25:0] HIGH_LAST  = {10'd0, HIGH_CYCLES} - 26'd1;
  localparam logic [25:0] LOW_LAST   = {10'd0, LOW_CYCLES} - 26'd1;

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [4:0]  pulses_left_q, pulses_left_d;
  logic        wms_q, wms_d;
  logic        busy_q, busy_d;
  logic        req_ready_q, req_ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Next-state, counter, pulse bookkeeping and next output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 26'd1;
    pulses_left_d = pulses_left_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 26'd0;
        if (req_valid && req_ready_q) begin
          if (mode_req > MAX_MODE) begin
            err_d = 1'b1;
          end else begin
            pulses_left_d = {1'b0, mode_req} + 5'd1;
            state_d       = GUARD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      GUARD: begin
        // ">=" rather than "==" keeps a corrupted count from running
        // around the whole 26-bit range.
        if (cnt_q >= GUARD_LAST) begin
          cnt_d   = 26'd0;
          state_d = HIGH;
        end else begin
          state_d = GUARD;
        end
      end

      HIGH: begin
        if (cnt_q >= HIGH_LAST) begin
          cnt_d = 26'd0;
          // A count of 1 or less means this was the last pulse. Zero can
          // only come from corruption; treat it the same way, so the
          // count never wraps.
          if (pulses_left_q <= 5'd1) begin
            pulses_left_d = 5'd0;
            state_d       = TAIL;
          end else begin
            pulses_left_d = pulses_left_q - 5'd1;
            state_d       = LOW;
          end
        end else begin
          state_d = HIGH;
        end
      end

      LOW: begin
        if (cnt_q >= LOW_LAST) begin
          cnt_d   = 26'd0;
          state_d = HIGH;
        end else begin
          state_d = LOW;
        end
      end

      TAIL: begin
        if (cnt_q >= LOW_LAST) begin
          cnt_d   = 26'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = TAIL;
        end
      end

      default: begin
        // Illegal code: drop back to IDLE with the line low.
        state_d       = IDLE;
        cnt_d         = 26'd0;
        pulses_left_d = 5'd0;
      end
    endcase

    // The output flops take the values that belong to the next state.
    wms_d       = (state_d == HIGH);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 26'd0;
      pulses_left_q <= 5'd0;
      wms_q         <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pulses_left_q <= pulses_left_d;
      wms_q         <= wms_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign wms       = wms_q;
  assign busy      = busy_q;
  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imaging_mode_pulse_tx.sv
// Bench for imaging_mode_pulse_tx, using a scaled-down guard, high and low time.
// The driver pushes one expected outcome for each accepted request. A
// monitor follows wms, busy, done and err, and compares against that record
// each time done or err appears. The bench also models the receiver: a long
// low time restarts its count, and each rising edge counts one pulse.
module tb_imaging_mode_pulse_tx;

  localparam int G = 10;
  localparam int H = 3;
  localparam int L = 2;
  localparam int MAXM = 8;
  localparam int RX_RESET = 8;

  logic       clk;
  logic       rst;
  logic [3:0] mode_req;
  logic       req_valid;
  logic       req_ready;
  logic       wms;
  logic       busy;
  logic       done;
  logic       err;

  imaging_mode_pulse_tx #(
    .GUARD_CYCLES(26'd10),
    .HIGH_CYCLES (16'd3),
    .LOW_CYCLES  (16'd2),
    .MAX_MODE    (4'd8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .wms      (wms),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    bit is_err;
    int mode;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // monitor state
  int   runs[$];
  int   exp_r[$];
  exp_t mon_e;
  logic cur_lvl = 1'b0;
  int   run_len = 0;
  int   busy_len = 0;
  int   rises = 0;
  logic prev_busy = 1'b0;

  // receiver model state
  logic rx_prev = 1'b0;
  bit   rx_pend = 1'b1;
  int   rx_mode = 0;
  int   rx_low = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input int act, input int expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int total(input int m);
    return G + (m + 1) * (H + L);
  endfunction

  // Receiver model and scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wms) begin
      if (!rx_prev) begin
        if (rx_pend) rx_mode = 0;
        else rx_mode++;
        rx_pend = 1'b0;
      end
      rx_low = 0;
    end else begin
      rx_low++;
      if (rx_low >= RX_RESET) rx_pend = 1'b1;
    end
    rx_prev = wms;

    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      chk(req_ready == !busy, "ready_vs_busy", int'(req_ready), int'(!busy));
      if (!busy) chk(wms == 1'b0, "wms_low_when_idle", int'(wms), 0);

      if (busy && !prev_busy) begin
        chk(exp_q.size() > 0 && !exp_q[0].is_err, "start_without_legal_request", exp_q.size(), 1);
        runs.delete();
        cur_lvl  = 1'b0;
        run_len  = 0;
        busy_len = 0;
        rises    = 0;
      end

      if (busy) begin
        busy_len++;
        if (wms !== cur_lvl) begin
          runs.push_back(run_len);
          if (wms) rises++;
          cur_lvl = wms;
          run_len = 1;
        end else begin
          run_len++;
        end
      end

      if (done) begin
        runs.push_back(run_len);
        chk(exp_q.size() != 0, "unexpected_done", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk(!mon_e.is_err, "done_for_rejected_mode", mon_e.mode, MAXM);
          exp_r.delete();
          exp_r.push_back(G);
          for (int k = 0; k <= mon_e.mode; k++) begin
            exp_r.push_back(H);
            exp_r.push_back(L);
          end
          chk(runs.size() == exp_r.size(), "wms_run_count", runs.size(), exp_r.size());
          if (runs.size() == exp_r.size()) begin
            for (int k = 0; k < runs.size(); k++)
              chk(runs[k] == exp_r[k], "wms_run_length", runs[k], exp_r[k]);
          end
          chk(rises == mon_e.mode + 1, "wms_rising_edges", rises, mon_e.mode + 1);
          chk(busy_len == total(mon_e.mode), "busy_length", busy_len, total(mon_e.mode));
          chk(cyc == mon_e.done_cyc, "done_cycle", cyc, mon_e.done_cyc);
          chk(rx_mode == mon_e.mode, "receiver_mode", rx_mode, mon_e.mode);
        end
      end

      if (err) begin
        chk(exp_q.size() != 0, "unexpected_err", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk(mon_e.is_err, "err_for_legal_mode", mon_e.mode, 15);
          chk(cyc == mon_e.done_cyc, "err_cycle", cyc, mon_e.done_cyc);
        end
      end
      prev_busy = busy;
    end
  end

  // Present a request and wait (bounded) for acceptance; record the expectation.
  task automatic send(input int m, input bit keep_valid, output int acc_cyc);
    exp_t e;
    int   t;
    mode_req  = 4'(m);
    req_valid = 1'b1;
    t = 0;
    acc_cyc = -1;
    while (!req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk(req_ready == 1'b1, "accept_timeout", t, 400);
      req_valid = 1'b0;
    end else begin
      acc_cyc    = cyc + 1;
      e.is_err   = (m > MAXM);
      e.mode     = m;
      e.done_cyc = e.is_err ? acc_cyc : acc_cyc + total(m);
      exp_q.push_back(e);
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected outcome has been seen and the block is idle.
  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      chk(exp_q.size() == 0, "idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    int a3, a5, a, m, gap, end_c, seen;
    logic pw;
    rst       = 1'b1;
    req_valid = 1'b0;
    mode_req  = 4'd0;
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1, "reset_req_ready", int'(req_ready), 1);
    chk(wms == 1'b0, "reset_wms", int'(wms), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(err == 1'b0, "reset_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Smallest and largest legal mode, then an out-of-range one.
    send(0, 1'b0, a);
    wait_idle();
    send(8, 1'b0, a);
    wait_idle();
    send(9, 1'b0, a);
    wait_idle();

    // Back-to-back: mode 5 held valid during a mode-3 transmission.
    send(3, 1'b1, a3);
    send(5, 1'b0, a5);
    chk(a5 == a3 + total(3) + 1, "b2b_accept_cycle", a5, a3 + total(3) + 1);
    wait_idle();

    // Reset during the second high pulse of mode 4.
    send(4, 1'b0, a);
    seen = 0;
    pw = wms;
    for (int t = 0; t < 300 && seen < 2; t++) begin
      @(negedge clk);
      if (wms && !pw) seen++;
      pw = wms;
    end
    chk(seen == 2 && wms == 1'b1, "second_high_reached", seen, 2);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk(wms == 1'b0, "wms_async_reset", int'(wms), 0);
    chk(busy == 1'b0, "busy_async_reset", int'(busy), 0);
    chk(req_ready == 1'b1, "ready_async_reset", int'(req_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1, 1'b0, a);
    wait_idle();

    // Loopback through the receiver model for every legal mode.
    for (int k = 0; k <= MAXM; k++) begin
      send(k, 1'b0, a);
      wait_idle();
    end

    // Random modes, with mode_req noise and ignored req_valid pulses while busy.
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) m = $urandom_range(0, MAXM);
      send(m, 1'b0, a);
      if (m <= MAXM) begin
        end_c = a + total(m);
        while (cyc + 3 < end_c) begin
          mode_req  = 4'($urandom_range(0, 15));
          req_valid = ($urandom_range(0, 4) == 0);
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      wait_idle();
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imaging_mode_pulse_tx.md
IMAGING_MODE_PULSE_TX -- requirements
Module: imaging_mode_pulse_tx

Interface
REQ-001 The block SHALL have a parameter GUARD_CYCLES, default 26'd55_000_000, giving the leading low time in clocks (1.1 s at 50 MHz); it SHALL exceed the receiver's 1 s counter-reset time.
REQ-002 The block SHALL have a parameter HIGH_CYCLES, default 16'd500, giving the high time of each pulse in clocks; its value SHALL be ≥2.
REQ-003 The block SHALL have a parameter LOW_CYCLES, default 16'd500, giving the low time between pulses and after the last pulse; its value SHALL be ≥2 and less than the receiver's reset time.
REQ-004 The block SHALL have a parameter MAX_MODE, default 4'd8, giving the highest legal imaging mode.
REQ-005 The block SHALL have port clk, input, 1 bit: the single 50 MHz clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port mode_req, input, 4 bits: the requested imaging mode (0..MAX_MODE).
REQ-008 The block SHALL have port req_valid, input, 1 bit: the request is present.
REQ-009 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-010 The block SHALL have port wms, output, 1 bit: the imaging-mode-select pulse line; it SHALL be driven directly from a flop.
REQ-011 The block SHALL have port busy, output, 1 bit: a transmission is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a 1-cycle pulse marking the end of a transmission.
REQ-013 The block SHALL have port err, output, 1 bit: a 1-cycle pulse marking a rejected (out-of-range) request.

Function
REQ-014 The protocol SHALL be: the line is held low for at least GUARD_CYCLES, then (mode+1) low-high-low pulses are sent, so that the receiver restarts at 0 and counts up to the mode.
REQ-015 The state machine SHALL have states IDLE, GUARD, HIGH, LOW and TAIL, and SHALL use safe encoding; any illegal state SHALL return to IDLE with wms=0.
REQ-016 In IDLE: req_ready=1, wms=0, busy=0; in all other states: req_ready=0, busy=1.
REQ-017 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-018 On an accepted request with mode_req>MAX_MODE: err=1 for the next cycle only, the state SHALL stay IDLE, wms SHALL stay 0, and no pulses SHALL be sent.
REQ-019 On an accepted request with a legal mode: pulses_left (5-bit) SHALL be loaded with mode_req+1, the 26-bit cycle counter SHALL be cleared, and the state SHALL become GUARD.
REQ-020 GUARD: wms=0 for exactly GUARD_CYCLES clocks, then the state SHALL become HIGH.
REQ-021 HIGH: wms=1 for exactly HIGH_CYCLES clocks, then pulses_left SHALL decrement; if the result is 0 the state SHALL become TAIL, otherwise LOW.
REQ-022 LOW: wms=0 for exactly LOW_CYCLES clocks, then the state SHALL become HIGH.
REQ-023 TAIL: wms=0 for exactly LOW_CYCLES clocks, then done=1 for 1 cycle and the state SHALL become IDLE.
REQ-024 The cycle counter SHALL clear on every state change and SHALL never wrap within a state.
REQ-025 For legal mode M, busy SHALL last exactly GUARD_CYCLES + (M+1)*HIGH_CYCLES + (M+1)*LOW_CYCLES clocks.
REQ-026 done SHALL coincide with the first IDLE cycle; req_ready=1 in that cycle.
REQ-027 A back-to-back request accepted in that first IDLE cycle SHALL begin a new GUARD, so that the receiver restarts its count from 0.
REQ-028 mode_req SHALL be sampled only at acceptance; changes to it while busy SHALL have no effect.
REQ-029 req_valid while busy SHALL be ignored and SHALL not be queued.
REQ-030 wms SHALL be glitch-free and SHALL change only on clk edges, except when rst asserts.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, wms=0, busy=0, done=0, err=0, req_ready=1, counters=0, pulses_left=0.
REQ-032 If rst asserts mid-transmission, the transmission SHALL be abandoned and wms SHALL go low immediately; the next request SHALL start again from GUARD.

Verification (GUARD_CYCLES=10, HIGH_CYCLES=3, LOW_CYCLES=2)
REQ-033 The bench SHALL check: mode_req=0 accepted -> wms low 10 clk, high 3, low 2; done on the 15th clock after acceptance; exactly 1 rising edge of wms.
REQ-034 The bench SHALL check: mode_req=8 -> 9 wms rising edges, each high 3 / low 2; busy=1 for 55 clk; then done=1 for 1 clk.
REQ-035 The bench SHALL check: mode_req=9 -> err=1 for 1 clk; wms=0 and busy=0 throughout; req_ready stays 1.
REQ-036 The bench SHALL check: mode 3 accepted, then req_valid with mode 5 held during busy -> exactly 4 pulses; mode 5 accepted only in the done cycle; then 6 pulses preceded by a 10-clk low.
REQ-037 The bench SHALL check: rst asserted during the 2nd HIGH of a mode-4 transmission -> wms=0 without waiting for a clock edge; after release, a mode-1 request produces a 10-clk low then 2 pulses.
REQ-038 The bench SHALL check: loopback of wms into the FPGA imaging-mode receiver for modes 0..8 (default parameters scaled down) -> the receiver's mode equals the requested mode after each done.
